// File: rtl/zapper_pkg.sv
// Shared types and default timing for the light-gun front end.
// Holds the sequence state encoding and the frame-counter width used by the top.
package zapper_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VS,
        BLACK,
        TARGET,
        RESULT
    } zap_state_e;

    localparam int FRAME_CNT_W         = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_BLACK_FRAMES    = 1;
    localparam int DEF_TARGET_FRAMES   = 1;

    // A one-cycle debounce would otherwise give a zero-width counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/zapper_frontend_debounce.sv
// Two-flop synchronizer, polarity normalisation and stable-count debounce.
// The output level toggles only after CYCLES consecutive cycles of disagreement.
module zapper_frontend_debounce
    import zapper_pkg::*;
#(
    parameter int CYCLES     = DEF_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level
);

    localparam int               CNT_W    = cnt_width(CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             active_s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    assign active_s = sync2_q ^ ACTIVE_LOW;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (active_s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/zapper_frontend.sv
// Light-gun front end: debounced trigger, press detect and the black/target
// flash sequence that samples the photodiode and reports one hit or miss per shot.
module zapper_frontend
    import zapper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter bit TRIG_ACTIVE_LOW  = 1'b1,
    parameter bit LIGHT_ACTIVE_LOW = 1'b1,
    parameter int BLACK_FRAMES     = DEF_BLACK_FRAMES,
    parameter int TARGET_FRAMES    = DEF_TARGET_FRAMES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic trigger_raw,
    input  logic light_raw,
    input  logic vsync,
    input  logic arm,
    output logic gun_shot,
    output logic shot_pulse,
    output logic flash_black,
    output logic flash_target,
    output logic hit,
    output logic miss,
    output logic busy
);

    localparam logic [FRAME_CNT_W-1:0] BLACK_LOAD  = FRAME_CNT_W'(BLACK_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] TARGET_LOAD = FRAME_CNT_W'(TARGET_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] FRAME_LAST  = FRAME_CNT_W'(1);

    logic                   gun_level;
    logic                   gun_prev_q;
    logic                   press;
    logic                   light_sync1_q;
    logic                   light_sync2_q;
    logic                   light_s;

    zap_state_e             state_q;
    zap_state_e             state_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_d;
    logic                   cheat_q;
    logic                   cheat_d;
    logic                   seen_q;
    logic                   seen_d;
    logic                   flash_black_q;
    logic                   flash_black_d;
    logic                   flash_target_q;
    logic                   flash_target_d;
    logic                   shot_accept;
    logic                   good_shot;

    zapper_frontend_debounce #(
        .CYCLES     (DEBOUNCE_CYCLES),
        .ACTIVE_LOW (TRIG_ACTIVE_LOW)
    ) u_trig_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (trigger_raw),
        .level   (gun_level)
    );

    // The photodiode is sampled per cycle inside a window, so it only needs syncing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            light_sync1_q <= 1'b0;
            light_sync2_q <= 1'b0;
            gun_prev_q    <= 1'b0;
        end else begin
            light_sync1_q <= light_raw;
            light_sync2_q <= light_sync1_q;
            gun_prev_q    <= gun_level;
        end
    end

    assign light_s = light_sync2_q ^ LIGHT_ACTIVE_LOW;
    assign press   = gun_level & ~gun_prev_q;

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        cheat_d     = cheat_q;
        seen_d      = seen_q;
        shot_accept = 1'b0;

        case (state_q)
            IDLE: begin
                if (press && arm) begin
                    shot_accept = 1'b1;
                    cheat_d     = 1'b0;
                    seen_d      = 1'b0;
                    state_d     = WAIT_VS;
                end
            end
            WAIT_VS: begin
                if (vsync) begin
                    frame_cnt_d = BLACK_LOAD;
                    state_d     = BLACK;
                end
            end
            BLACK: begin
                // Light on a black screen means the gun is aimed at a lamp, not the TV.
                if (light_s) begin
                    cheat_d = 1'b1;
                end
                if (vsync) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        frame_cnt_d = TARGET_LOAD;
                        state_d     = TARGET;
                    end else begin
                        frame_cnt_d = frame_cnt_q - 1'b1;
                    end
                end
            end
            TARGET: begin
                if (light_s) begin
                    seen_d = 1'b1;
                end
                if (vsync) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        state_d = RESULT;
                    end else begin
                        frame_cnt_d = frame_cnt_q - 1'b1;
                    end
                end
            end
            RESULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        flash_black_d  = (state_d == BLACK);
        flash_target_d = (state_d == TARGET);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            frame_cnt_q    <= '0;
            cheat_q        <= 1'b0;
            seen_q         <= 1'b0;
            flash_black_q  <= 1'b0;
            flash_target_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_cnt_q    <= frame_cnt_d;
            cheat_q        <= cheat_d;
            seen_q         <= seen_d;
            flash_black_q  <= flash_black_d;
            flash_target_q <= flash_target_d;
        end
    end

    assign good_shot    = seen_q & ~cheat_q;
    assign gun_shot     = gun_level;
    assign shot_pulse   = shot_accept;
    assign flash_black  = flash_black_q;
    assign flash_target = flash_target_q;
    assign hit          = (state_q == RESULT) &&  good_shot;
    assign miss         = (state_q == RESULT) && !good_shot;
    assign busy         = (state_q != IDLE);

endmodule

// File: doc/zapper_frontend.md
Name: zapper_frontend

Overview:
- Light-gun front end. Sits directly upstream of the shot-counting FSM and drives its gun-shot input with a debounced trigger level.
- On each accepted trigger press it runs the flash-and-sense sequence:
  - blanks the screen for a set number of frames, then draws the target box;
  - samples the photodiode during both windows;
  - emits exactly one hit or miss pulse per shot to the scoring logic.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required before gun_shot changes (5 ms at 50 MHz).
- TRIG_ACTIVE_LOW, 1: 1 = trigger_raw low means pressed.
- LIGHT_ACTIVE_LOW, 1: 1 = light_raw low means light detected.
- BLACK_FRAMES, 1: frames of full-black flash, range 1..15.
- TARGET_FRAMES, 1: frames of target-box flash, range 1..15.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- trigger_raw  in  1  raw gun trigger, asynchronous
- light_raw  in  1  raw photodiode, asynchronous
- vsync  in  1  one-cycle pulse at the start of each video frame, synchronous to clk
- arm  in  1  1 = shots are accepted (driven by game/round logic)
- gun_shot  out  1  debounced trigger level, 1 = pressed
- shot_pulse  out  1  one-cycle pulse when a press is accepted
- flash_black  out  1  video mux: draw full black
- flash_target  out  1  video mux: draw white target box
- hit  out  1  one-cycle pulse, shot registered light on target only
- miss  out  1  one-cycle pulse, shot failed
- busy  out  1  sequence in progress (state != IDLE)

Behaviour:
- Reset: all outputs 0, debounce counter 0, synchronizers cleared, state IDLE. Reset asserted mid-sequence aborts it immediately; no hit/miss is emitted.
- Synchronizers: trigger_raw and light_raw each pass through 2 flops. Polarity is normalised after sync, so trig_s and light_s are 1 = active.
- Debounce:
  - counter clears whenever trig_s == gun_shot;
  - otherwise it increments;
  - when it reaches DEBOUNCE_CYCLES-1, gun_shot toggles and the counter clears.
  - Latency from a clean raw edge to gun_shot: 2 + DEBOUNCE_CYCLES cycles. A glitch shorter than DEBOUNCE_CYCLES never changes gun_shot.
- Press detect: press = gun_shot rises (registered copy 0, current 1).
- Sequence FSM:
  - IDLE:
    - press && arm: shot_pulse=1 this cycle, clear cheat and seen flags, go WAIT_VS.
    - press while arm=0, or while not IDLE: ignored, no pulse. gun_shot still tracks the trigger.
  - WAIT_VS: on vsync, load frame counter = BLACK_FRAMES, go BLACK. A vsync in the same cycle as the press is not counted (FSM is still in IDLE).
  - BLACK:
    - flash_black=1;
    - any cycle with light_s=1 sets cheat;
    - each vsync decrements the counter;
    - on the vsync where the counter == 1: load TARGET_FRAMES, go TARGET.
  - TARGET:
    - flash_target=1;
    - light_s=1 sets seen;
    - each vsync decrements the counter;
    - on the vsync where the counter == 1: go RESULT.
  - RESULT, one cycle: hit = seen && !cheat, miss = !hit, go IDLE. Flash outputs are 0.
- hit and miss are mutually exclusive. Exactly one of them pulses per shot_pulse unless reset intervenes.
- arm dropping mid-sequence does not abort; the result is still emitted.
- busy=1 in WAIT_VS, BLACK, TARGET and RESULT.
- flash_black and flash_target are never both 1. Both are registered and change on the clock after the vsync that switches state.
- Frame counter is 4 bits and never wraps (loaded ≥1; exit at 1).
- Debounce counter width = clog2(DEBOUNCE_CYCLES); saturation is not needed.

Decomposition:
- Shared package:
  - state enum: IDLE, WAIT_VS, BLACK, TARGET, RESULT;
  - FRAME_CNT_W = 4;
  - default timing constants.
- Sub-module: debouncer, which owns its own synchronizer, counter and polarity parameter. It is instantiated once for the trigger. The light path uses only a synchronizer.

Test Plan:
- Bounce: DEBOUNCE_CYCLES=8, 3-cycle trigger glitch -> gun_shot stays 0. Hold 20 cycles -> gun_shot=1 exactly 10 cycles after the raw edge; release mirrors this.
- Clean hit: BLACK_FRAMES=1, TARGET_FRAMES=2, arm=1, press, light dark through black, light on 1 cycle during 2nd target frame -> shot_pulse once, flash_black for 1 frame, flash_target for 2 frames, hit=1 for one cycle, miss=0, busy falls the cycle after.
- Cheat: light held on throughout -> miss=1, hit=0.
- No light: dark throughout -> miss=1. Second press while busy -> no shot_pulse, still exactly one result.
- arm=0 press -> no shot_pulse, busy=0, no flash.
- Reset in TARGET -> all outputs 0 next edge and no hit/miss. Press vsync-coincident -> BLACK starts on the following vsync.
